// File: rtl/store_write_buffer.sv
// store_write_buffer: in-order posted store buffer with a drain FSM and load RAW hazard detection
module store_write_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_we,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    input  logic [31:0] core_raddr,
    output logic        core_stall,
    output logic        raw_hit,
    output logic        wb_empty,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_REQ  = 1'b1;

    logic [31:0]   r_addr [DEPTH];
    logic [31:0]   r_data [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [AW:0]   r_count;
    logic [0:0]    r_state;
    logic [AW:0]   w_count_nxt;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic [AW-1:0] w_off [DEPTH];
    logic [DEPTH-1:0] w_hit;

    // A full buffer rejects the store even if the head drains this cycle.
    assign w_full      = r_count == L_FULL;
    assign w_push      = core_we && !w_full && !rst;
    assign w_pop       = r_state == S_REQ && mem_ack;
    assign w_count_nxt = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

    assign core_stall = core_we && w_full && !rst;
    assign mem_req    = r_state == S_REQ;
    assign mem_addr   = r_addr[r_head];
    assign mem_wdata  = r_data[r_head];
    assign wb_empty   = r_count == '0 && !mem_req;
    assign raw_hit    = |w_hit;

    // An entry is live when its distance from head is below count; match on word address.
    genvar i;
    generate
        for (i = 0; i < DEPTH; i++) begin : g_hit
            assign w_off[i] = AW'(i) - r_head;
            assign w_hit[i] = ({1'b0, w_off[i]} < r_count) &&
                              (((r_addr[i] ^ core_raddr) & 32'hFFFF_FFFC) == 32'd0);
        end
    endgenerate

    // Entry storage is written at tail on an accepted store and never reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_tail] <= core_addr;
            r_data[r_tail] <= core_wdata;
        end
    end

    // Pointers, occupancy and drain FSM; REQ is held whenever entries remain after this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_state <= S_IDLE;
        end else begin
            r_head  <= w_pop ? r_head + 1'b1 : r_head;
            r_tail  <= w_push ? r_tail + 1'b1 : r_tail;
            r_count <= w_count_nxt;
            r_state <= (w_count_nxt != '0) ? S_REQ : S_IDLE;
        end
    end
endmodule

// File: tb/tb_store_write_buffer.sv
// tb_store_write_buffer: directed and randomized checks against a queue-based reference model
module tb_store_write_buffer;
    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        core_we;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic [31:0] core_raddr;
    logic        core_stall;
    logic        raw_hit;
    logic        wb_empty;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;

    int n_chk = 0;
    int n_err = 0;

    logic [63:0] q[$];
    logic        m_req = 1'b0;

    store_write_buffer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_raddr (core_raddr),
        .core_stall (core_stall),
        .raw_hit    (raw_hit),
        .wb_empty   (wb_empty),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    // One clock: drive at negedge, compare outputs against the model, then advance the model.
    task automatic cyc(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] ra, input logic ack, input logic r);
        logic hit;
        int   n;
        @(negedge clk);
        core_we = we; core_addr = a; core_wdata = d; core_raddr = ra; mem_ack = ack; rst = r;
        #1;
        hit = 1'b0;
        foreach (q[k]) if (q[k][63:34] == ra[31:2]) hit = 1'b1;
        check("core_stall", {31'd0, core_stall}, {31'd0, we && q.size() == DEPTH && !r});
        check("raw_hit", {31'd0, raw_hit}, {31'd0, hit});
        check("wb_empty", {31'd0, wb_empty}, {31'd0, q.size() == 0 && !m_req});
        check("mem_req", {31'd0, mem_req}, {31'd0, m_req});
        if (m_req) begin
            check("mem_addr", mem_addr, q[0][63:32]);
            check("mem_wdata", mem_wdata, q[0][31:0]);
        end
        @(posedge clk);
        if (r) begin
            q.delete();
            m_req = 1'b0;
        end else begin
            n = q.size();
            if (m_req && ack) void'(q.pop_front());
            if (we && n < DEPTH) q.push_back({a, d});
            m_req = q.size() > 0;
        end
    endtask

    initial begin
        clk = 0; rst = 1; core_we = 0; core_addr = 0; core_wdata = 0; core_raddr = 0; mem_ack = 0;
        repeat (2) @(posedge clk);
        cyc(0, 0, 0, 0, 0, 1);
        // single store, late ack
        cyc(1, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0);
        check("single_req", {31'd0, m_req}, 32'd1);
        repeat (3) cyc(0, 0, 0, 32'h100, 0, 0);
        cyc(0, 0, 0, 32'h100, 1, 0);
        cyc(0, 0, 0, 32'h100, 0, 0);
        check("single_empty", {31'd0, wb_empty}, 32'd1);
        // fill to full, fifth store held until a drain makes room
        for (int k = 0; k < 5; k++) cyc(1, 32'(k * 4), 32'hA000 + 32'(k), 32'h40, 0, 0);
        cyc(1, 32'h10, 32'hA004, 32'h40, 0, 0);
        cyc(1, 32'h10, 32'hA004, 32'h40, 1, 0);
        cyc(1, 32'h10, 32'hA004, 32'h10, 0, 0);
        repeat (6) cyc(0, 0, 0, 32'h0, 1, 0);
        check("fill_drained", 32'(q.size()), 32'd0);
        // back-to-back drain of three entries
        for (int k = 0; k < 3; k++) cyc(1, 32'h300 + 32'(k * 4), 32'hB000 + 32'(k), 0, 0, 0);
        repeat (5) cyc(0, 0, 0, 0, 1, 0);
        // hazard on word address
        cyc(1, 32'h200, 32'h1234, 32'h200, 0, 0);
        cyc(0, 0, 0, 32'h202, 0, 0);
        cyc(0, 0, 0, 32'h204, 0, 0);
        cyc(0, 0, 0, 32'h202, 1, 0);
        cyc(0, 0, 0, 32'h202, 0, 0);
        // steady push and pop at count two, wrapping pointers
        cyc(1, 32'h400, 32'h1, 0, 0, 0);
        cyc(1, 32'h404, 32'h2, 0, 0, 0);
        for (int k = 0; k < 10; k++) cyc(1, 32'h408 + 32'(k * 4), 32'h3 + 32'(k), 32'h408, 1, 0);
        repeat (4) cyc(0, 0, 0, 0, 1, 0);
        // reset while a handshake is pending
        cyc(1, 32'h500, 32'h5, 0, 0, 0);
        cyc(1, 32'h504, 32'h6, 0, 0, 0);
        cyc(0, 0, 0, 32'h500, 1, 1);
        cyc(0, 0, 0, 32'h500, 1, 0);
        cyc(1, 32'h600, 32'h7, 32'h600, 0, 0);
        cyc(0, 0, 0, 32'h600, 1, 0);
        cyc(0, 0, 0, 32'h600, 0, 0);
        // randomized traffic over a small address pool so hazards and wraps are frequent
        for (int k = 0; k < 3000; k++)
            cyc($urandom_range(0, 99) < 60, 32'h800 + 32'($urandom_range(0, 7) * 4),
                $urandom, 32'h800 + 32'($urandom_range(0, 31)),
                $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 2);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
